// File: rtl/clk_en_pkg.sv
// Shared state codes and helpers for the fractional clock-enable generator.
// Optional phase-realign input is enabled with the CLK_EN_SYNC_EN macro (see clk_en_gen).
package clk_en_pkg;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;

  typedef logic [1:0] chan_state_t;

  function automatic int lock_cnt_w(input int lock_cyc);
    return $clog2(lock_cyc + 1);
  endfunction

  // A ratio can only be generated as pulses when 0 < mul <= div.
  function automatic logic ratio_legal(input logic [31:0] mul, input logic [31:0] div);
    return (div != 32'd0) && (mul != 32'd0) && (mul <= div);
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: settle/lock FSM, settle counter, fractional accumulator and ce register.
// The sync input realigns the phase of a non-ERR channel; tie it low when unused.
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int W        = 16,
  parameter int LOCK_CYC = 64,
  parameter int DEF_MUL  = 1,
  parameter int DEF_DIV  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_wr,
  input  logic         sync,
  input  logic [W-1:0] cfg_mul,
  input  logic [W-1:0] cfg_div,
  output logic         ce,
  output logic         locked,
  output logic         err
);

  localparam int CNT_W = lock_cnt_w(LOCK_CYC);

  chan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       acc;
  logic [W-1:0]     mul;
  logic [W-1:0]     div;
  logic [W:0]       sum;
  logic             legal_now;
  logic             wr_legal;
  logic             run;

  always_comb begin
    legal_now = ratio_legal(32'(mul), 32'(div));
    wr_legal  = ratio_legal(32'(cfg_mul), 32'(cfg_div));
    sum       = acc + {1'b0, mul};
    run       = (state != ST_ERR) && legal_now;
  end

  // A stored ratio that is illegal can only come from the reset defaults; it is caught in SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_SETTLE;
      cnt   <= '0;
      acc   <= '0;
      mul   <= W'(DEF_MUL);
      div   <= W'(DEF_DIV);
      ce    <= 1'b0;
    end else if (cfg_wr) begin
      mul   <= cfg_mul;
      div   <= cfg_div;
      cnt   <= '0;
      acc   <= '0;
      ce    <= 1'b0;
      state <= wr_legal ? ST_SETTLE : ST_ERR;
    end else begin
      if (state == ST_SETTLE) begin
        if (!legal_now)
          state <= ST_ERR;
        else if (cnt == CNT_W'(LOCK_CYC - 1))
          state <= ST_LOCKED;
        else
          cnt <= cnt + CNT_W'(1);
      end

      if (!run || sync) begin
        acc <= '0;
        ce  <= 1'b0;
      end else if (sum >= {1'b0, div}) begin
        acc <= sum - {1'b0, div};
        ce  <= 1'b1;
      end else begin
        acc <= sum;
        ce  <= 1'b0;
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign err    = (state == ST_ERR);

endmodule

// File: rtl/clk_en_gen.sv
// N-channel fractional clock-enable generator: config handshake/decode, error pulse, ready reduction.
// Define CLK_EN_SYNC_EN to add the 'sync' phase-realign input.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 16,
  parameter int LOCK_CYC = 64,
  parameter int DEF_MUL  = 1,
  parameter int DEF_DIV  = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef CLK_EN_SYNC_EN
  input  logic            sync,
`endif
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_mul,
  input  logic [W-1:0]    cfg_div,
  output logic            cfg_err,
  output logic [N_CH-1:0] ce,
  output logic [N_CH-1:0] locked,
  output logic [N_CH-1:0] ch_err,
  output logic            ready
);

  logic            accept;
  logic            sync_int;
  logic [N_CH-1:0] cfg_wr;

`ifdef CLK_EN_SYNC_EN
  assign sync_int = sync;
`else
  assign sync_int = 1'b0;
`endif

  assign accept = cfg_valid & cfg_ready;

  always_comb begin
    cfg_wr = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (accept && (cfg_ch == CH_W'(i)))
        cfg_wr[i] = 1'b1;
    end
  end

  // ready lags locked by one cycle because it is registered from the channel outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      ready     <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept && (32'(cfg_ch) >= 32'(N_CH));
      ready     <= &locked;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_en_chan #(
      .W       (W),
      .LOCK_CYC(LOCK_CYC),
      .DEF_MUL (DEF_MUL),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .cfg_wr (cfg_wr[g]),
      .sync   (sync_int),
      .cfg_mul(cfg_mul),
      .cfg_div(cfg_div),
      .ce     (ce[g]),
      .locked (locked[g]),
      .err    (ch_err[g])
    );
  end

endmodule
